// File: rtl/mor1kx_bus_arbiter_cappuccino.sv
// ---------------------------------------------------------------------------
// mor1kx_bus_arbiter_cappuccino
//
// Shares a single memory port between the instruction fetch bus (ibus) and
// the load/store bus (dbus) in single-port cappuccino builds. One transaction
// is in flight at a time. A three-state grant FSM (IDLE, GNT_I, GNT_D)
// registers the port request and attributes. It returns ack/err/data
// combinationally to the current owner. A watchdog converts a hung access
// into a bus error.
//
// Optional feature (compile-time macro):
//   MOR1KX_BUS_ARB_ROUND_ROBIN_EN
//     defined   : an IDLE tie goes to the requester that did not win the
//                 previous grant. The first tie after reset goes to dbus.
//     undefined : fixed priority. dbus always wins an IDLE tie.
//
// Parameters:
//   OPTION_OPERAND_WIDTH  address width
//   TIMEOUT_CYCLES        grant cycles before a forced error (0 = watchdog off)
//   TIMEOUT_WIDTH         watchdog counter width (must hold TIMEOUT_CYCLES)
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   ibus_req_i / ibus_adr_i       fetch request and address
//   ibus_ack_o / ibus_err_o       fetch completion, forwarded from the port
//   ibus_dat_o                    fetch read data (valid with ibus_ack_o)
//   dbus_req_i / dbus_we_i        LSU request and write enable
//   dbus_adr_i / dbus_bsel_i      LSU address and byte selects
//   dbus_dat_i                    LSU write data
//   dbus_ack_o / dbus_err_o       LSU completion, forwarded from the port
//   dbus_dat_o                    LSU read data (valid with dbus_ack_o)
//   mem_req_o / mem_we_o          shared port request and write enable
//   mem_bsel_o / mem_adr_o        shared port byte selects and address
//   mem_dat_o                     shared port write data
//   mem_ack_i / mem_err_i         shared port completion
//   mem_dat_i                     shared port read data
// ---------------------------------------------------------------------------
module mor1kx_bus_arbiter_cappuccino #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int TIMEOUT_CYCLES       = 256,
  parameter int TIMEOUT_WIDTH        = 9
) (
  input  logic                            clk,
  input  logic                            rst,
  // fetch unit
  input  logic                            ibus_req_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] ibus_adr_i,
  output logic                            ibus_ack_o,
  output logic                            ibus_err_o,
  output logic [31:0]                     ibus_dat_o,
  // load/store unit
  input  logic                            dbus_req_i,
  input  logic                            dbus_we_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] dbus_adr_i,
  input  logic [3:0]                      dbus_bsel_i,
  input  logic [31:0]                     dbus_dat_i,
  output logic                            dbus_ack_o,
  output logic                            dbus_err_o,
  output logic [31:0]                     dbus_dat_o,
  // shared memory port
  output logic                            mem_req_o,
  output logic                            mem_we_o,
  output logic [3:0]                      mem_bsel_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] mem_adr_o,
  output logic [31:0]                     mem_dat_o,
  input  logic                            mem_ack_i,
  input  logic                            mem_err_i,
  input  logic [31:0]                     mem_dat_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMEOUT_WIDTH-1:0] WD_LIMIT =
    TIMEOUT_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t                   state;
  logic                     orphan;
  logic [TIMEOUT_WIDTH-1:0] wdog;

`ifdef MOR1KX_BUS_ARB_ROUND_ROBIN_EN
  // 0 = ibus won the most recent grant, 1 = dbus did
  logic                     last_grant;
`endif

  logic in_grant;
  logic owner_req;
  logic other_req;
  logic done;
  logic timeout;
  logic fwd_ok;
  logic fwd_ack;
  logic fwd_err;
  logic tie_dbus;
  logic idle_pick_d;
  logic grant_d;
  logic grant_i;
  logic release_port;

  // Decides whether dbus wins in IDLE, given who is requesting and how a
  // tie should be broken.
  function automatic logic pick_dbus(input logic ireq, input logic dreq,
                                     input logic tie_to_dbus);
    return dreq && (!ireq || tie_to_dbus);
  endfunction

`ifdef MOR1KX_BUS_ARB_ROUND_ROBIN_EN
  assign tie_dbus = ~last_grant;
`else
  assign tie_dbus = 1'b1;
`endif

  assign in_grant  = (state != IDLE);
  assign owner_req = (state == GNT_I) ? ibus_req_i :
                     (state == GNT_D) ? dbus_req_i : 1'b0;
  assign other_req = (state == GNT_I) ? dbus_req_i :
                     (state == GNT_D) ? ibus_req_i : 1'b0;

  assign done    = in_grant && (mem_ack_i || mem_err_i);
  // A completion in the same cycle as the limit counts as a completion.
  assign timeout = WD_EN && in_grant && !done && (wdog == WD_LIMIT);

  // Responses reach the owner only while it still wants them. A flushed
  // (orphaned) access is swallowed. Nothing leaks out in a reset cycle.
  assign fwd_ok  = in_grant && owner_req && !orphan && !rst;
  assign fwd_err = fwd_ok && (mem_err_i || timeout);
  assign fwd_ack = fwd_ok && mem_ack_i && !mem_err_i;

  assign ibus_ack_o = fwd_ack && (state == GNT_I);
  assign ibus_err_o = fwd_err && (state == GNT_I);
  assign ibus_dat_o = ibus_ack_o ? mem_dat_i : 32'h0;
  assign dbus_ack_o = fwd_ack && (state == GNT_D);
  assign dbus_err_o = fwd_err && (state == GNT_D);
  assign dbus_dat_o = dbus_ack_o ? mem_dat_i : 32'h0;

  // The finishing owner is never a candidate in its completion cycle. The
  // hand-over therefore only ever goes to the other requester, with no bubble.
  assign idle_pick_d  = pick_dbus(ibus_req_i, dbus_req_i, tie_dbus);
  assign grant_d      = ((state == IDLE)  && idle_pick_d) ||
                        ((state == GNT_I) && done && dbus_req_i);
  assign grant_i      = ((state == IDLE)  && ibus_req_i && !idle_pick_d) ||
                        ((state == GNT_D) && done && ibus_req_i);
  assign release_port = in_grant && (done || timeout) && !grant_d && !grant_i;

  // Grant FSM: state, registered port outputs, watchdog and flush tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mem_req_o  <= 1'b0;
      mem_we_o   <= 1'b0;
      mem_bsel_o <= 4'h0;
      mem_adr_o  <= '0;
      mem_dat_o  <= 32'h0;
      wdog       <= '0;
      orphan     <= 1'b0;
`ifdef MOR1KX_BUS_ARB_ROUND_ROBIN_EN
      last_grant <= 1'b0;
`endif
    end else if (grant_d) begin
      state      <= GNT_D;
      mem_req_o  <= 1'b1;
      mem_we_o   <= dbus_we_i;
      mem_bsel_o <= dbus_bsel_i;
      mem_adr_o  <= dbus_adr_i;
      mem_dat_o  <= dbus_dat_i;
      wdog       <= '0;
      orphan     <= 1'b0;
`ifdef MOR1KX_BUS_ARB_ROUND_ROBIN_EN
      last_grant <= 1'b1;
`endif
    end else if (grant_i) begin
      // Fetches are always full-word reads
      state      <= GNT_I;
      mem_req_o  <= 1'b1;
      mem_we_o   <= 1'b0;
      mem_bsel_o <= 4'hf;
      mem_adr_o  <= ibus_adr_i;
      mem_dat_o  <= 32'h0;
      wdog       <= '0;
      orphan     <= 1'b0;
`ifdef MOR1KX_BUS_ARB_ROUND_ROBIN_EN
      last_grant <= 1'b0;
`endif
    end else if (release_port) begin
      state      <= IDLE;
      mem_req_o  <= 1'b0;
      mem_we_o   <= 1'b0;
      mem_bsel_o <= 4'h0;
      mem_adr_o  <= '0;
      mem_dat_o  <= 32'h0;
      wdog       <= '0;
      orphan     <= 1'b0;
    end else if (in_grant) begin
      // Still waiting: the port attributes stay frozen even if the owner
      // flushes. The response of a flushed access must still be drained.
      if (WD_EN) begin
        wdog <= wdog + 1'b1;
      end
      if (!owner_req) begin
        orphan <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mor1kx_bus_arbiter_cappuccino.sv
// ---------------------------------------------------------------------------
// tb_mor1kx_bus_arbiter_cappuccino
//
// Directed bench for the ibus/dbus single-port arbiter. Each table row is one
// clock cycle. The row's inputs are applied after the falling edge. All outputs
// are compared shortly afterwards, before the next rising edge. Hand-written
// sequences cover the watchdog, reset in the middle of a grant, and tie
// arbitration.
// The DUT runs with an 8-cycle watchdog.
// ---------------------------------------------------------------------------
module tb_mor1kx_bus_arbiter_cappuccino;

  logic        clk;
  logic        rst;
  logic        ibus_req_i;
  logic [31:0] ibus_adr_i;
  logic        ibus_ack_o;
  logic        ibus_err_o;
  logic [31:0] ibus_dat_o;
  logic        dbus_req_i;
  logic        dbus_we_i;
  logic [31:0] dbus_adr_i;
  logic [3:0]  dbus_bsel_i;
  logic [31:0] dbus_dat_i;
  logic        dbus_ack_o;
  logic        dbus_err_o;
  logic [31:0] dbus_dat_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_bsel_o;
  logic [31:0] mem_adr_o;
  logic [31:0] mem_dat_o;
  logic        mem_ack_i;
  logic        mem_err_i;
  logic [31:0] mem_dat_i;

  mor1kx_bus_arbiter_cappuccino #(
    .OPTION_OPERAND_WIDTH(32),
    .TIMEOUT_CYCLES      (8),
    .TIMEOUT_WIDTH       (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ibus_req_i (ibus_req_i),
    .ibus_adr_i (ibus_adr_i),
    .ibus_ack_o (ibus_ack_o),
    .ibus_err_o (ibus_err_o),
    .ibus_dat_o (ibus_dat_o),
    .dbus_req_i (dbus_req_i),
    .dbus_we_i  (dbus_we_i),
    .dbus_adr_i (dbus_adr_i),
    .dbus_bsel_i(dbus_bsel_i),
    .dbus_dat_i (dbus_dat_i),
    .dbus_ack_o (dbus_ack_o),
    .dbus_err_o (dbus_err_o),
    .dbus_dat_o (dbus_dat_o),
    .mem_req_o  (mem_req_o),
    .mem_we_o   (mem_we_o),
    .mem_bsel_o (mem_bsel_o),
    .mem_adr_o  (mem_adr_o),
    .mem_dat_o  (mem_dat_o),
    .mem_ack_i  (mem_ack_i),
    .mem_err_i  (mem_err_i),
    .mem_dat_i  (mem_dat_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dw;
    logic [31:0] da;
    logic [3:0]  bs;
    logic [31:0] dd;
    logic        ma;
    logic        me;
    logic [31:0] md;
    logic [137:0] exp_out;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [137:0] outs();
    return {ibus_ack_o, ibus_err_o, ibus_dat_o, dbus_ack_o, dbus_err_o, dbus_dat_o,
            mem_req_o, mem_we_o, mem_bsel_o, mem_adr_o, mem_dat_o};
  endfunction

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic add(input logic r, input logic ir, input logic [31:0] ia,
                     input logic dr, input logic dw, input logic [31:0] da,
                     input logic [3:0] bs, input logic [31:0] dd,
                     input logic ma, input logic me, input logic [31:0] md,
                     input logic eia, input logic eie, input logic [31:0] eid,
                     input logic eda, input logic ede, input logic [31:0] edd,
                     input logic emr, input logic emw, input logic [3:0] emb,
                     input logic [31:0] ema, input logic [31:0] emd);
    vec_t v;
    v.r = r; v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da;
    v.bs = bs; v.dd = dd; v.ma = ma; v.me = me; v.md = md;
    v.exp_out = {eia, eie, eid, eda, ede, edd, emr, emw, emb, ema, emd};
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic ir, input logic [31:0] ia,
                       input logic dr, input logic dw, input logic [31:0] da,
                       input logic [3:0] bs, input logic [31:0] dd,
                       input logic ma, input logic me, input logic [31:0] md);
    rst = r; ibus_req_i = ir; ibus_adr_i = ia;
    dbus_req_i = dr; dbus_we_i = dw; dbus_adr_i = da; dbus_bsel_i = bs; dbus_dat_i = dd;
    mem_ack_i = ma; mem_err_i = me; mem_dat_i = md;
  endtask

  logic exp_d;
  logic [31:0] win_adr;

  initial begin
    drive(1, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);

    // rst ir ia | dr dw da bs dd | ma me md || iack ierr idat | dack derr ddat | mreq mwe mbsel madr mdat
    // reset state
    add(1,0,32'h0,     0,0,32'h0,4'h0,32'h0,        0,0,32'h0,       0,0,32'h0,        0,0,32'h0, 0,0,4'h0,32'h0,32'h0);
    // lone fetch, acked in its third grant cycle
    add(0,1,32'h100,   0,0,32'h0,4'h0,32'h0,        0,0,32'h0,       0,0,32'h0,        0,0,32'h0, 0,0,4'h0,32'h0,32'h0);
    add(0,1,32'h100,   0,0,32'h0,4'h0,32'h0,        0,0,32'h0,       0,0,32'h0,        0,0,32'h0, 1,0,4'hf,32'h100,32'h0);
    add(0,1,32'h100,   0,0,32'h0,4'h0,32'h0,        0,0,32'h0,       0,0,32'h0,        0,0,32'h0, 1,0,4'hf,32'h100,32'h0);
    add(0,1,32'h100,   0,0,32'h0,4'h0,32'h0,        1,0,32'h15000000,1,0,32'h15000000, 0,0,32'h0, 1,0,4'hf,32'h100,32'h0);
    add(0,0,32'h0,     0,0,32'h0,4'h0,32'h0,        0,0,32'h0,       0,0,32'h0,        0,0,32'h0, 0,0,4'h0,32'h0,32'h0);
    // simultaneous requests: dbus write first, then straight to the fetch
    add(0,1,32'h200,   1,1,32'h2000,4'h3,32'hcafef00d, 0,0,32'h0,    0,0,32'h0,        0,0,32'h0, 0,0,4'h0,32'h0,32'h0);
    add(0,1,32'h200,   1,1,32'h2000,4'h3,32'hcafef00d, 0,0,32'h0,    0,0,32'h0,        0,0,32'h0, 1,1,4'h3,32'h2000,32'hcafef00d);
    add(0,1,32'h200,   1,1,32'h2000,4'h3,32'hcafef00d, 1,0,32'h0,    0,0,32'h0,        1,0,32'h0, 1,1,4'h3,32'h2000,32'hcafef00d);
    add(0,1,32'h200,   0,0,32'h0,4'h0,32'h0,        0,0,32'h0,       0,0,32'h0,        0,0,32'h0, 1,0,4'hf,32'h200,32'h0);
    add(0,1,32'h200,   0,0,32'h0,4'h0,32'h0,        1,0,32'h12345678,1,0,32'h12345678, 0,0,32'h0, 1,0,4'hf,32'h200,32'h0);
    add(0,0,32'h0,     0,0,32'h0,4'h0,32'h0,        0,0,32'h0,       0,0,32'h0,        0,0,32'h0, 0,0,4'h0,32'h0,32'h0);
    // fetch flushed one cycle into its grant; a new fetch is up when the stale ack lands
    add(0,1,32'h300,   0,0,32'h0,4'h0,32'h0,        0,0,32'h0,       0,0,32'h0,        0,0,32'h0, 0,0,4'h0,32'h0,32'h0);
    add(0,1,32'h300,   0,0,32'h0,4'h0,32'h0,        0,0,32'h0,       0,0,32'h0,        0,0,32'h0, 1,0,4'hf,32'h300,32'h0);
    add(0,0,32'h0,     0,0,32'h0,4'h0,32'h0,        0,0,32'h0,       0,0,32'h0,        0,0,32'h0, 1,0,4'hf,32'h300,32'h0);
    add(0,0,32'h0,     0,0,32'h0,4'h0,32'h0,        0,0,32'h0,       0,0,32'h0,        0,0,32'h0, 1,0,4'hf,32'h300,32'h0);
    add(0,1,32'h400,   0,0,32'h0,4'h0,32'h0,        1,0,32'hdeadbeef,0,0,32'h0,        0,0,32'h0, 1,0,4'hf,32'h300,32'h0);
    add(0,1,32'h400,   0,0,32'h0,4'h0,32'h0,        0,0,32'h0,       0,0,32'h0,        0,0,32'h0, 0,0,4'h0,32'h0,32'h0);
    add(0,1,32'h400,   0,0,32'h0,4'h0,32'h0,        1,0,32'habcd0001,1,0,32'habcd0001, 0,0,32'h0, 1,0,4'hf,32'h400,32'h0);
    add(0,0,32'h0,     0,0,32'h0,4'h0,32'h0,        0,0,32'h0,       0,0,32'h0,        0,0,32'h0, 0,0,4'h0,32'h0,32'h0);
    // ack and err together: err wins
    add(0,1,32'h500,   0,0,32'h0,4'h0,32'h0,        0,0,32'h0,       0,0,32'h0,        0,0,32'h0, 0,0,4'h0,32'h0,32'h0);
    add(0,1,32'h500,   0,0,32'h0,4'h0,32'h0,        1,1,32'h55aa55aa,0,1,32'h0,        0,0,32'h0, 1,0,4'hf,32'h500,32'h0);
    add(0,0,32'h0,     0,0,32'h0,4'h0,32'h0,        0,0,32'h0,       0,0,32'h0,        0,0,32'h0, 0,0,4'h0,32'h0,32'h0);
    // dbus read that ends in a port error
    add(0,0,32'h0,     1,0,32'h3000,4'hf,32'h0,     0,0,32'h0,       0,0,32'h0,        0,0,32'h0, 0,0,4'h0,32'h0,32'h0);
    add(0,0,32'h0,     1,0,32'h3000,4'hf,32'h0,     0,1,32'h0,       0,0,32'h0,        0,1,32'h0, 1,0,4'hf,32'h3000,32'h0);
    add(0,0,32'h0,     0,0,32'h0,4'h0,32'h0,        0,0,32'h0,       0,0,32'h0,        0,0,32'h0, 0,0,4'h0,32'h0,32'h0);

    repeat (2) @(negedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].r, vecs[i].ir, vecs[i].ia, vecs[i].dr, vecs[i].dw, vecs[i].da,
            vecs[i].bs, vecs[i].dd, vecs[i].ma, vecs[i].me, vecs[i].md);
      #2;
      check($sformatf("row%0d", i), {22'h0, outs()}, {22'h0, vecs[i].exp_out});
    end

    // Watchdog: an unanswered dbus read errors in its 8th grant cycle
    @(negedge clk);
    drive(0, 0, 0, 1, 0, 32'h4000, 4'hf, 0, 0, 0, 0);
    #2;
    check("wd_idle_req", {159'h0, mem_req_o}, 160'h0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      #2;
      check($sformatf("wd_cycle%0d", k), {157'h0, dbus_ack_o, dbus_err_o, mem_req_o},
            {157'h0, 1'b0, (k == 8), 1'b1});
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 4'h0, 0, 1, 0, 32'h77777777);
    #2;
    check("wd_late_ack", {125'h0, dbus_ack_o, dbus_err_o, dbus_dat_o, mem_req_o}, 160'h0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    #2;
    check("wd_after", {22'h0, outs()}, 160'h0);

    // Reset in the middle of a fetch grant
    @(negedge clk);
    drive(0, 1, 32'h600, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    @(negedge clk);
    #2;
    check("rst_pre_adr", {127'h0, mem_req_o, mem_adr_o}, {127'h0, 1'b1, 32'h600});
    @(negedge clk);
    drive(1, 1, 32'h600, 0, 0, 0, 4'h0, 0, 1, 0, 32'h99);
    #2;
    check("rst_no_fwd", {126'h0, ibus_ack_o, ibus_err_o, ibus_dat_o}, 160'h0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    #2;
    check("rst_after", {22'h0, outs()}, 160'h0);

    // Four consecutive ties out of IDLE; the loser backs off on the
    // winner's completion so every decision is made from IDLE.
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      drive(0, 1, 32'h700, 1, 0, 32'h800, 4'hf, 0, 0, 0, 0);
      #2;
      check($sformatf("tie%0d_idle", t), {159'h0, mem_req_o}, 160'h0);
`ifdef MOR1KX_BUS_ARB_ROUND_ROBIN_EN
      exp_d = ((t % 2) == 0);
`else
      exp_d = 1'b1;
`endif
      win_adr = exp_d ? 32'h800 : 32'h700;
      @(negedge clk);
      drive(0, !exp_d, 32'h700, exp_d, 0, 32'h800, 4'hf, 0, 1, 0, 32'h1000 + t);
      #2;
      check($sformatf("tie%0d_win", t), {125'h0, mem_req_o, mem_adr_o, ibus_ack_o, dbus_ack_o},
            {125'h0, 1'b1, win_adr, !exp_d, exp_d});
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    #2;
    check("final_idle", {22'h0, outs()}, 160'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
